button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter N_BTN, default 5, number of button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, consecutive stable samples required to accept a level change (range 2..2^24).
REQ-003 SHALL have parameter REPEAT_DELAY, default 25_000_000, cycles from accepted press to first auto-repeat pulse (range 2..2^28).
REQ-004 SHALL have parameter REPEAT_PERIOD, default 5_000_000, cycles between subsequent auto-repeat pulses (range 2..2^28).
REQ-005 SHALL have parameter REPEAT_MASK, default 5'b11110, per-channel auto-repeat enable; bit i set enables repeat on channel i.
REQ-006 clk  input  1  system clock (50 MHz); all state on rising edge.
REQ-007 rst_n  input  1  reset; one clock, asynchronous and active-low.
REQ-008 btn_raw  input  N_BTN  asynchronous, bouncing pushbutton levels (1 = pressed).
REQ-009 btn_level  output  N_BTN  debounced button level.
REQ-010 btn_pulse  output  N_BTN  single-cycle press/repeat events; drives the game core's btn_pulse port directly.

Function
REQ-011 Each channel SHALL pass btn_raw through a 2-flop synchronizer (s1, s2) before any other logic.
REQ-012 Each channel SHALL hold a stable register and a debounce counter; on each edge where s2 != stable the counter increments, where s2 == stable the counter clears to 0.
REQ-013 When the counter equals DEBOUNCE_CYCLES-1 and s2 != stable, stable SHALL take s2 and the counter SHALL clear on that edge.
REQ-014 Latency: btn_raw held high from sampling edge 0 SHALL make btn_level rise after edge DEBOUNCE_CYCLES+1; release is symmetric.
REQ-015 Any single-cycle s2 glitch back to the stable value SHALL restart the debounce count from 0.
REQ-016 Per-channel repeat FSM states: IDLE, HOLD, REPEAT; registered, one-hot-free binary encoding.
REQ-017 IDLE: on the edge stable goes 0->1, btn_pulse[i] SHALL be 1 for exactly the following cycle; FSM -> HOLD (if REPEAT_MASK[i]) else remains IDLE-with-held-level, and the timer loads 0.
REQ-018 HOLD: timer increments each cycle; when it reaches REPEAT_DELAY-1, btn_pulse[i] SHALL pulse one cycle, timer clears, FSM -> REPEAT.
REQ-019 REPEAT: timer increments; at REPEAT_PERIOD-1 btn_pulse[i] SHALL pulse one cycle and timer clears; FSM stays in REPEAT.
REQ-020 Any state: stable 1->0 SHALL force IDLE and clear the timer on that edge; no pulse on release.
REQ-021 Release and press accepted on consecutive debounce decisions SHALL still yield exactly one pulse per accepted press.
REQ-022 btn_pulse SHALL never be high for two consecutive cycles on any channel.
REQ-023 Channels SHALL be fully independent; simultaneous presses SHALL produce simultaneous pulses.
REQ-024 Counter widths SHALL be $clog2 of their limits; no wrap-around is reachable.

Reset
REQ-025 rst_n low SHALL asynchronously clear s1, s2, stable, counters, timers, and FSMs to IDLE; btn_level = 0, btn_pulse = 0.
REQ-026 A button held through reset release SHALL be accepted as a fresh press after DEBOUNCE_CYCLES+1 edges and produce one pulse.
REQ-027 rst_n asserted mid-debounce or mid-repeat SHALL discard all progress; no pulse on reset deassertion.

Structure
REQ-028 Package btn_cond_pkg SHALL hold channel index constants (BTN_C=0, BTN_U=1, BTN_L=2, BTN_R=3, BTN_D=4) and the repeat FSM state enum.
REQ-029 One sub-module btn_channel (sync + debounce + repeat FSM, one bit) SHALL be instantiated N_BTN times via generate.

Verification (bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-030 btn_raw[1] 0->1 held -> btn_level[1] rises after edge 5; btn_pulse[1] high exactly one cycle.
REQ-031 btn_raw[2] toggling 1,0,1,0 each cycle for 20 cycles then 0 -> btn_level[2] and btn_pulse[2] stay 0 throughout.
REQ-032 btn_raw[3] held 40 cycles -> pulses at press, +10, then every 3 cycles until release is accepted; none after.
REQ-033 btn_raw[0] (REPEAT_MASK bit 0 clear) held 40 cycles -> exactly one pulse.
REQ-034 All five raw inputs rise in the same cycle -> btn_pulse = 5'b11111 for one cycle.
REQ-035 rst_n pulsed low during REPEAT with btn_raw[4] held -> outputs 0 immediately; one new pulse after 5 edges post-deassertion.

Source files
------------

// File: rtl/btn_cond_pkg.sv
// Shared definitions for the pushbutton conditioner: channel indices of the
// board's five-way pad, the per-channel repeat FSM states and a width helper.
package btn_cond_pkg;

    localparam int BTN_C = 0;
    localparam int BTN_U = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_D = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchronizer, stable-level debounce and a press/auto-repeat
// pulse generator. btn_pulse is registered so it is glitch-free for the consumer.
module btn_channel
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000,
    parameter bit REPEAT_EN       = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [CW-1:0] CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] DELAY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LAST = TW'(REPEAT_PERIOD - 1);

    logic          s1_q, s2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    rep_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pulse_q, pulse_d;
    logic          accept, rise, fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= btn_raw;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Any sample that agrees with the stable level restarts the count.
    always_comb begin
        accept   = (s2_q != stable_q) && (cnt_q == CNT_LAST);
        stable_d = accept ? s2_q : stable_q;
        if ((s2_q == stable_q) || accept) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        rise = accept && s2_q;
        fall = accept && !s2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (fall) begin
            state_d = ST_IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d = REPEAT_EN ? ST_HOLD : ST_IDLE;
                        timer_d = '0;
                    end
                end
                ST_HOLD: begin
                    if (timer_q == DELAY_LAST) begin
                        state_d = ST_REPEAT;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (timer_q == PERIOD_LAST) begin
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    // A release decision suppresses any repeat pulse due on the same edge.
    always_comb begin
        pulse_d = 1'b0;
        if (!fall) begin
            case (state_q)
                ST_IDLE:   pulse_d = rise;
                ST_HOLD:   pulse_d = (timer_q == DELAY_LAST);
                ST_REPEAT: pulse_d = (timer_q == PERIOD_LAST);
                default:   pulse_d = 1'b0;
            endcase
        end
    end

    assign btn_level = stable_q;
    assign btn_pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces N_BTN raw pushbuttons and produces level plus press/auto-repeat
// pulses; each channel is an independent btn_channel instance.
module button_conditioner
    import btn_cond_pkg::*;
#(
    parameter int               N_BTN           = 5,
    parameter int               DEBOUNCE_CYCLES = 1_000_000,
    parameter int               REPEAT_DELAY    = 25_000_000,
    parameter int               REPEAT_PERIOD   = 5_000_000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = 5'b11110
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD),
            .REPEAT_EN      (REPEAT_MASK[gi])
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn_raw  (btn_raw[gi]),
            .btn_level(btn_level[gi]),
            .btn_pulse(btn_pulse[gi])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3: a cycle table plus hand sequences for glitch, repeat and reset cases.
module tb_button_conditioner;
    import btn_cond_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] btn_raw;
    logic [4:0] btn_level;
    logic [4:0] btn_pulse;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] raw;
        logic [4:0] lvl;
        logic [4:0] pls;
    } vec_t;

    vec_t tbl[30];

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN          (5),
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3),
        .REPEAT_MASK    (5'b11110)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic step_check(input string name, input int k,
                              input logic [4:0] exp_lvl, input logic [4:0] exp_pls);
        tick();
        $display("%s k=%0d raw=%b level=%b pulse=%b", name, k, btn_raw, btn_level, btn_pulse);
        check({name, "_level"}, btn_level, exp_lvl);
        check({name, "_pulse"}, btn_pulse, exp_pls);
    endtask

    task automatic do_reset();
        btn_raw = '0;
        rst_n   = 1'b0;
        #1;
        check("reset_level", btn_level, 5'b0);
        check("reset_pulse", btn_pulse, 5'b0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic fill(input int a, input int b,
                        input logic [4:0] r, input logic [4:0] l, input logic [4:0] p);
        for (int i = a; i <= b; i++) tbl[i] = '{r, l, p};
    endtask

    // Hold one channel for 'hold' edges then release; press pulse at edge 5,
    // repeat pulses at 15 + 3n (if enabled) until release is accepted at hold+5.
    task automatic hold_test(input string name, input int ch, input int hold,
                             input int total, input bit rep);
        logic [4:0] el, ep;
        for (int k = 0; k < total; k++) begin
            btn_raw     = '0;
            btn_raw[ch] = (k < hold);
            el     = '0;
            ep     = '0;
            el[ch] = (k >= 5) && (k < hold + 5);
            ep[ch] = (k == 5) || (rep && k >= 15 && k < hold + 5 && ((k - 15) % 3) == 0);
            step_check(name, k, el, ep);
        end
    endtask

    initial begin
        logic [4:0] u_m, all_m, el, ep;
        u_m   = 5'b1 << BTN_U;
        all_m = 5'b11111;

        fill(0, 4,   u_m,   5'b0,  5'b0);
        fill(5, 5,   u_m,   u_m,   u_m);
        fill(6, 7,   u_m,   u_m,   5'b0);
        fill(8, 12,  5'b0,  u_m,   5'b0);
        fill(13, 15, 5'b0,  5'b0,  5'b0);
        fill(16, 20, all_m, 5'b0,  5'b0);
        fill(21, 21, all_m, all_m, all_m);
        fill(22, 22, all_m, all_m, 5'b0);
        fill(23, 27, 5'b0,  all_m, 5'b0);
        fill(28, 29, 5'b0,  5'b0,  5'b0);

        do_reset();
        for (int i = 0; i < 30; i++) begin
            btn_raw = tbl[i].raw;
            step_check("vec", i, tbl[i].lvl, tbl[i].pls);
        end

        // Toggling raw input never survives the debounce window.
        do_reset();
        for (int k = 0; k < 28; k++) begin
            btn_raw        = '0;
            btn_raw[BTN_L] = (k < 20) && ((k % 2) == 0);
            step_check("glitch", k, 5'b0, 5'b0);
        end

        // One-cycle dropout restarts the count: acceptance slips from edge 5 to 9.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            btn_raw        = '0;
            btn_raw[BTN_U] = (k != 3);
            el             = '0;
            ep             = '0;
            el[BTN_U]      = (k >= 9);
            ep[BTN_U]      = (k == 9);
            step_check("restart", k, el, ep);
        end

        do_reset();
        hold_test("repeat", BTN_R, 40, 55, 1'b1);
        do_reset();
        hold_test("norepeat", BTN_C, 40, 55, 1'b0);

        // Reset while repeating: outputs drop at once, fresh press after reset.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            btn_raw        = 5'b1 << BTN_D;
            el             = '0;
            ep             = '0;
            el[BTN_D]      = (k >= 5);
            ep[BTN_D]      = (k == 5) || (k >= 15 && ((k - 15) % 3) == 0);
            step_check("prerst", k, el, ep);
        end
        rst_n = 1'b0;
        #1;
        check("rst_async_level", btn_level, 5'b0);
        check("rst_async_pulse", btn_pulse, 5'b0);
        tick();
        check("rst_hold_level", btn_level, 5'b0);
        tick();
        check("rst_hold_pulse", btn_pulse, 5'b0);
        rst_n = 1'b1;
        for (int k = 0; k < 13; k++) begin
            el        = '0;
            ep        = '0;
            el[BTN_D] = (k >= 5);
            ep[BTN_D] = (k == 5);
            step_check("postrst", k, el, ep);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
